// File: rtl/spi_transmitter.sv
// spi_transmitter: SPI mode-0 master transmit block. Sends one byte per frame
// on MOSI with SS/SCLK framing and a one-cycle DONE pulse at frame end.
// Build option: define SPI_TX_LSB_FIRST_EN to send bit 0 first (default MSB first).
module spi_transmitter #(
  parameter int unsigned DIV = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       WRITE,
  input  logic       TE,
  input  logic [7:0] DATA,
  output logic       MOSI,
  output logic       SCLK,
  output logic       SS,
  output logic       FULL_STATE,
  output logic       EMPTY_STATE,
  output logic       DONE
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] shreg;
  logic [7:0] shreg_shifted;
  logic [7:0] div_cnt;
  logic [3:0] edge_cnt;
  logic       sclk_q;
  logic       tx_bit;
  logic       div_hit;
  logic       fall;
  logic       active;

`ifdef SPI_TX_LSB_FIRST_EN
  assign tx_bit        = shreg[0];
  assign shreg_shifted = {1'b0, shreg[7:1]};
`else
  assign tx_bit        = shreg[7];
  assign shreg_shifted = {shreg[6:0], 1'b0};
`endif

  // State register; CLR wins over any pending WRITE.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    div_hit     = TE && (div_cnt == DIV_LAST);
    fall        = (state == ST_SHIFT) && div_hit && sclk_q;
    active      = (state == ST_SETUP) || (state == ST_SHIFT);
    state_next  = state;
    case (state)
      ST_IDLE:  if (WRITE) state_next = ST_SETUP;
      ST_SETUP: if (div_hit) state_next = ST_SHIFT;
      ST_SHIFT: if (fall && (edge_cnt == 4'd7)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    SS          = ~active;
    SCLK        = sclk_q;
    MOSI        = active ? tx_bit : 1'b0;
    FULL_STATE  = active;
    EMPTY_STATE = ~active;
    DONE        = (state == ST_DONE);
  end

  // Datapath: shift register, half-period divider, falling-edge counter, SCLK.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      shreg    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (WRITE) begin
            shreg    <= DATA;
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (TE) begin
            div_cnt <= div_hit ? 8'd0 : div_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (TE) begin
            if (div_hit) begin
              div_cnt <= '0;
              sclk_q  <= ~sclk_q;
              // Falling edge: present the next bit in the same cycle SCLK drops.
              if (sclk_q) begin
                shreg    <= shreg_shifted;
                edge_cnt <= edge_cnt + 4'd1;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          shreg    <= '0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          sclk_q   <= 1'b0;
        end
        default: begin
          shreg    <= '0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          sclk_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transmitter.sv
// Directed, table-driven bench for spi_transmitter (DIV=2 and DIV=1 instances).
module tb_spi_transmitter;

  logic       clk;
  logic       clr;
  logic       write_a, te_a;
  logic [7:0] data_a;
  logic       mosi_a, sclk_a, ss_a, full_a, empty_a, done_a;
  logic       write_b, te_b;
  logic [7:0] data_b;
  logic       mosi_b, sclk_b, ss_b, full_b, empty_b, done_b;

  int n_checks = 0;
  int n_pass   = 0;

  spi_transmitter #(.DIV(2)) dut_a (
    .CLK(clk), .CLR(clr), .WRITE(write_a), .TE(te_a), .DATA(data_a),
    .MOSI(mosi_a), .SCLK(sclk_a), .SS(ss_a),
    .FULL_STATE(full_a), .EMPTY_STATE(empty_a), .DONE(done_a)
  );

  spi_transmitter #(.DIV(1)) dut_b (
    .CLK(clk), .CLR(clr), .WRITE(write_b), .TE(te_b), .DATA(data_b),
    .MOSI(mosi_b), .SCLK(sclk_b), .SS(ss_b),
    .FULL_STATE(full_b), .EMPTY_STATE(empty_b), .DONE(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         stall_at;
    int         stall_len;
    int         wr_at;
    logic [7:0] wr_data;
    logic [7:0] exp_byte;
    int         exp_done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Order in which bits of a byte appear on the wire, packed first-bit-in-[7].
  function automatic logic [7:0] wire_order(input logic [7:0] d);
    logic [7:0] r;
`ifdef SPI_TX_LSB_FIRST_EN
    for (int unsigned i = 0; i < 8; i++) r[7-i] = d[i];
`else
    r = d;
`endif
    return r;
  endfunction

  // Launch a frame at the current post-edge instant (edge 0) and follow it to exp_done+1.
  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] recv;
    int rises, done_at, win_err, frz_err;
    logic prev_sclk, hold_sclk, hold_mosi;
    recv = '0; rises = 0; done_at = -1; win_err = 0; frz_err = 0;
    prev_sclk = sclk_a; hold_sclk = 1'b0; hold_mosi = 1'b0;
    data_a = v.data; write_a = 1'b1; te_a = 1'b1;
    for (int e = 1; e <= v.exp_done + 1; e++) begin
      @(posedge clk); #1;
      if (sclk_a && !prev_sclk) begin
        rises++;
        recv = {recv[6:0], mosi_a};
      end
      prev_sclk = sclk_a;
      if (done_a && done_at < 0) done_at = e;
      if (ss_a !== (e >= v.exp_done)) win_err++;
      if (full_a !== (e < v.exp_done)) win_err++;
      if (empty_a !== ~full_a) win_err++;
      if (done_a !== (e == v.exp_done)) win_err++;
      if (e == v.stall_at) begin
        hold_sclk = sclk_a;
        hold_mosi = mosi_a;
      end
      if (e > v.stall_at && e <= v.stall_at + v.stall_len &&
          (sclk_a !== hold_sclk || mosi_a !== hold_mosi)) frz_err++;
      te_a = !(e >= v.stall_at && e < v.stall_at + v.stall_len);
      if (e == 1) write_a = 1'b0;
      if (v.wr_at != 0 && e == v.wr_at) begin
        write_a = 1'b1;
        data_a  = v.wr_data;
      end else if (e == v.wr_at + 1) begin
        write_a = 1'b0;
      end
    end
    write_a = 1'b0;
    te_a    = 1'b1;
    check({tag, " bits"}, recv, wire_order(v.exp_byte));
    check({tag, " rises"}, rises, 8);
    check({tag, " done_edge"}, done_at, v.exp_done);
    check({tag, " window_errs"}, win_err, 0);
    check({tag, " freeze_errs"}, frz_err, 0);
    check({tag, " idle_ss"}, ss_a, 1);
  endtask

  vec_t vecs[6];
  vec_t v_ff;

  initial begin
    vecs[0] = '{8'hA5, 0, 0, 0, 8'h00, 8'hA5, 35};   // basic frame
    vecs[1] = '{8'hA5, 10, 10, 0, 8'h00, 8'hA5, 45}; // 10-cycle stall in SHIFT
    vecs[2] = '{8'hA5, 0, 0, 10, 8'h3C, 8'hA5, 35};  // write mid-frame ignored
    vecs[3] = '{8'h3C, 0, 0, 0, 8'h00, 8'h3C, 35};   // back-to-back after DONE
    vecs[4] = '{8'h81, 0, 0, 35, 8'hFF, 8'h81, 35};  // write during DONE ignored
    vecs[5] = '{8'h5A, 1, 3, 0, 8'h00, 8'h5A, 38};   // 3-cycle stall in SETUP
    v_ff    = '{8'hFF, 0, 0, 0, 8'h00, 8'hFF, 35};

    // Reset with WRITE asserted: CLR must win.
    clr = 1'b1; write_a = 1'b1; data_a = 8'hFF; te_a = 1'b1;
    write_b = 1'b1; data_b = 8'hFF; te_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    check("rst ss", ss_a, 1);
    check("rst sclk", sclk_a, 0);
    check("rst mosi", mosi_a, 0);
    check("rst empty", empty_a, 1);
    check("rst full", full_a, 0);
    check("rst done", done_a, 0);
    check("rst ss_b", ss_b, 1);
    clr = 1'b0; write_a = 1'b0; write_b = 1'b0;
    @(posedge clk); #1;
    check("post_rst ss", ss_a, 1);
    check("post_rst full", full_a, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-frame with CLR, then a normal frame.
    begin
      int done_seen;
      done_seen = 0;
      data_a = 8'hA5; write_a = 1'b1;
      for (int e = 1; e <= 13; e++) begin
        @(posedge clk); #1;
        if (e == 1) write_a = 1'b0;
        if (e == 12) clr = 1'b1;
      end
      clr = 1'b0;
      check("abort ss", ss_a, 1);
      check("abort sclk", sclk_a, 0);
      check("abort mosi", mosi_a, 0);
      check("abort full", full_a, 0);
      check("abort empty", empty_a, 1);
      check("abort done", done_a, 0);
      for (int e = 0; e < 40; e++) begin
        @(posedge clk); #1;
        if (done_a || !ss_a) done_seen++;
      end
      check("abort no_done", done_seen, 0);
      run_frame(v_ff, "after_abort");
    end

    // DIV=1 instance: SCLK toggles every cycle in SHIFT.
    begin
      logic [7:0] recv;
      int rises, done_at;
      logic prev;
      recv = '0; rises = 0; done_at = -1; prev = sclk_b;
      data_b = 8'h01; write_b = 1'b1;
      for (int e = 1; e <= 19; e++) begin
        @(posedge clk); #1;
        if (e == 1) write_b = 1'b0;
        if (sclk_b && !prev) begin
          rises++;
          recv = {recv[6:0], mosi_b};
        end
        prev = sclk_b;
        if (done_b && done_at < 0) done_at = e;
      end
      check("div1 bits", recv, wire_order(8'h01));
      check("div1 rises", rises, 8);
      check("div1 done_edge", done_at, 18);
      check("div1 idle_ss", ss_b, 1);
      check("div1 empty", empty_b, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_transmitter.md
# spi_transmitter

Master-side SPI transmit block: the MOSI-driving counterpart of the SPI receiver in the midterm SPI interface. The controller writes one byte on `DATA`, and the block generates `SS`, `SCLK` (mode 0: CPOL=0, CPHA=0) and `MOSI`, shifting the byte out MSB first. `FULL_STATE`/`EMPTY_STATE` report buffer status with the same meaning the receiver uses. `DONE` pulses once at the end of each frame.

## Interface
- `DIV`, default 2: `SCLK` half-period in `CLK` cycles; legal range 1..255.
- `CLK`, in, 1: system clock; all logic on the rising edge.
- `CLR`, in, 1: reset, synchronous, active-high.
- `WRITE`, in, 1: load request; sampled only in IDLE.
- `TE`, in, 1: transmit enable; 0 freezes the divider, `SCLK`, `MOSI` and the bit count.
- `DATA`, in, 8: byte to send; captured on an accepted `WRITE`.
- `MOSI`, out, 1: serial data out.
- `SCLK`, out, 1: serial clock; idles at 0.
- `SS`, out, 1: slave select, active-low.
- `FULL_STATE`, out, 1: 1 while a byte is loaded and not yet fully sent.
- `EMPTY_STATE`, out, 1: inverse of `FULL_STATE`.
- `DONE`, out, 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, SETUP, SHIFT, DONE. Internal registers:
  - 8-bit shift register
  - 8-bit divider counter, 0..DIV-1
  - 4-bit falling-edge counter, 0..8
- IDLE:
  - Outputs: `SS`=1, `SCLK`=0, `MOSI`=0.
  - When `WRITE`=1, capture `DATA` into the shift register, set `FULL_STATE`, and move to SETUP.
- SETUP:
  - `SS`=0 and `MOSI` = shift register MSB.
  - The divider counts while `TE`=1. After DIV counted cycles, move to SHIFT with the divider at 0.
- SHIFT:
  - The divider counts while `TE`=1. When it reaches DIV-1, it wraps to 0 and `SCLK` toggles on the next edge.
  - On each 1→0 `SCLK` transition, in the same cycle:
    - shift the register left by one (zero fill), so `MOSI` shows the next bit;
    - increment the edge counter.
  - On the 8th falling edge, move to DONE.
- DONE (one cycle):
  - Outputs: `SS`=1, `SCLK`=0, `MOSI`=0, `DONE`=1.
  - Clear `FULL_STATE`, then return to IDLE.
- `WRITE` outside IDLE (including DONE) is ignored; the byte in flight is never altered.
- `CLR` has priority over everything, including `WRITE` in the same cycle.
- `CLR`=1 mid-frame aborts the frame. On the next edge all outputs take reset values, and no `DONE` pulse is produced.
- Reset values:
  - Outputs: `MOSI`=0, `SCLK`=0, `SS`=1, `FULL_STATE`=0, `EMPTY_STATE`=1, `DONE`=0.
  - Internal: state IDLE, shift register 8'h00, all counters 0.

## Timing
- `WRITE` accepted at edge 0 (`TE` held 1):
  - `SS` falls and `MOSI` = bit 7 at edge 1.
  - First `SCLK` rise at edge DIV+DIV+1.
  - 8 rising edges, 16 half-periods in total.
  - `DONE`=1 at edge 17·DIV+1; IDLE again at 17·DIV+2.
- `MOSI` is stable for a full `SCLK` half-period before every rising edge. It changes only on falling edges or on SETUP entry.
- Each `TE`=0 cycle in SETUP or SHIFT delays every later event by exactly one cycle. `TE` has no effect in IDLE or DONE.
- Back-to-back: a `WRITE` accepted on the first IDLE cycle after DONE starts a new frame with the same latency. The minimum frame spacing is 17·DIV+2 cycles.
- DIV=1: `SCLK` toggles every cycle in SHIFT.

## Configuration
- Macro `SPI_TX_LSB_FIRST_EN`:
  - Defined: bit 0 is sent first. The register shifts right, `MOSI` = register LSB, and zero fill enters at the MSB.
  - Undefined (default): MSB first, as described above.
- Frame timing, `FULL_STATE`/`EMPTY_STATE` and `DONE` are identical in both builds.

## Test plan
- Reset: hold `CLR`=1 for 2 cycles with `WRITE`=1 and `DATA`=8'hFF → `SS`=1, `SCLK`=0, `MOSI`=0, `EMPTY_STATE`=1, `FULL_STATE`=0, `DONE`=0, state stays IDLE.
- Basic frame, DIV=2, `DATA`=8'hA5, `TE`=1:
  - `MOSI` sampled on `SCLK` rises reads 1,0,1,0,0,1,0,1, with exactly 8 rises.
  - `SS` low on edges 1..34, `DONE` pulse at edge 35, `FULL_STATE`=1 on edges 1..34.
- Stall: same frame, `TE`=0 for 10 cycles inside SHIFT → `SCLK` and `MOSI` held constant, same bit sequence, `DONE` at edge 45.
- Ignored write: `WRITE` with `DATA`=8'h3C at edge 10 of the 8'hA5 frame → transmitted byte is still 8'hA5. A `WRITE` of 8'h3C on the first IDLE cycle after DONE then sends 0,0,1,1,1,1,0,0.
- Abort: `CLR`=1 at edge 12 of a frame → reset values on edge 13, no `DONE` pulse. A following `WRITE` of 8'hFF sends eight 1s with normal timing.
- With `SPI_TX_LSB_FIRST_EN` defined, `DATA`=8'h01, DIV=1 → `MOSI` on rises reads 1,0,0,0,0,0,0,0 and `DONE` at edge 18.
